// File: rtl/note_uart_tx_pkg.sv
// Shared types and constants for the note-event UART transmitter.
// Frame byte0 carries a fixed header nibble plus key bit 8.
package note_uart_tx_pkg;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'b00,
        TX_START = 2'b01,
        TX_DATA  = 2'b10,
        TX_STOP  = 2'b11
    } tx_state_t;

    localparam logic [3:0] NOTE_FRAME_HDR = 4'hA;
    localparam logic       UART_LINE_IDLE = 1'b1;

    function automatic logic [7:0] note_hdr_byte(input logic note_msb);
        return {NOTE_FRAME_HDR, 3'b000, note_msb};
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// Single-byte 8N1 shifter with baud counter. A start strobe taken on the
// last stop-bit cycle chains the next byte with no idle gap.
module uart_byte_tx
    import note_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       done,
    output logic       uart_tx
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);

    tx_state_t     state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [2:0]    bit_r, bit_s;
    logic [7:0]    data_r, data_s;
    logic          tx_r, tx_s;
    logic          wrap_s, done_s;

    // Next-state, shift and line-level logic
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        bit_s   = bit_r;
        data_s  = data_r;
        tx_s    = tx_r;
        done_s  = 1'b0;
        wrap_s  = (cnt_r == CNT_LAST);

        if (state_r == TX_IDLE) begin
            cnt_s = CNT_ZERO;
        end else if (wrap_s) begin
            cnt_s = CNT_ZERO;
        end else begin
            cnt_s = cnt_r + CNT_ONE;
        end

        case (state_r)
            TX_IDLE: begin
                if (start) begin
                    state_s = TX_START;
                    data_s  = data;
                    tx_s    = 1'b0;
                end else begin
                    tx_s = UART_LINE_IDLE;
                end
            end
            TX_START: begin
                if (wrap_s) begin
                    state_s = TX_DATA;
                    bit_s   = 3'd0;
                    tx_s    = data_r[0];
                end else begin
                    tx_s = 1'b0;
                end
            end
            TX_DATA: begin
                if (wrap_s) begin
                    if (bit_r == 3'd7) begin
                        state_s = TX_STOP;
                        tx_s    = 1'b1;
                    end else begin
                        // data_r shifts so the next bit is always at [1]
                        bit_s  = bit_r + 3'd1;
                        tx_s   = data_r[1];
                        data_s = {1'b0, data_r[7:1]};
                    end
                end else begin
                    tx_s = tx_r;
                end
            end
            TX_STOP: begin
                if (wrap_s) begin
                    done_s = 1'b1;
                    if (start) begin
                        state_s = TX_START;
                        data_s  = data;
                        tx_s    = 1'b0;
                    end else begin
                        state_s = TX_IDLE;
                        tx_s    = UART_LINE_IDLE;
                    end
                end else begin
                    tx_s = 1'b1;
                end
            end
            default: begin
                state_s = TX_IDLE;
                tx_s    = UART_LINE_IDLE;
            end
        endcase
    end

    // Shifter state registers; line forced idle-high on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= TX_IDLE;
            cnt_r   <= CNT_ZERO;
            bit_r   <= 3'd0;
            data_r  <= 8'h00;
            tx_r    <= UART_LINE_IDLE;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            bit_r   <= bit_s;
            data_r  <= data_s;
            tx_r    <= tx_s;
        end
    end

    assign done    = done_s;
    assign uart_tx = tx_r;

endmodule

// File: rtl/note_uart_tx.sv
// Key-change detector, snapshot FIFO and two-byte frame sequencer that
// reports every Pin_Note change over the UART line.
module note_uart_tx
    import note_uart_tx_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_en,
    input  logic [8:0] Pin_Note,
    output logic       uart_tx,
    output logic       busy,
    output logic       overflow
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ZERO = (AW + 1)'(1'b0);
    localparam logic [AW:0] PTR_ONE  = (AW + 1)'(1'b1);

    logic [8:0]  prev_r;
    logic        en_q_r;
    logic [8:0]  fifo_r [FIFO_DEPTH];
    logic [AW:0] wr_ptr_r, rd_ptr_r, wr_ptr_s, rd_ptr_s;
    logic        active_r, active_s;
    logic        byte_sel_r, byte_sel_s;
    logic [7:0]  snap_r, snap_s;
    logic        busy_r, busy_s;
    logic        overflow_r, overflow_s;
    logic        empty_s, full_s, en_rise_s, event_s;
    logic        push_s, drop_s, pop_s, start_s, done_s;
    logic [7:0]  byte_s;
    logic [8:0]  head_s;

    // Change detection and FIFO status (extra pointer bit separates full from empty)
    always_comb begin
        empty_s   = (wr_ptr_r == rd_ptr_r);
        full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                    (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        head_s    = fifo_r[rd_ptr_r[AW-1:0]];
        en_rise_s = tx_en & ~en_q_r;
        event_s   = tx_en & ((Pin_Note != prev_r) | en_rise_s);
    end

    // Frame sequencing: pop, byte0 header, byte1 payload, chaining frames
    always_comb begin
        pop_s      = 1'b0;
        start_s    = 1'b0;
        byte_s     = 8'h00;
        active_s   = active_r;
        byte_sel_s = byte_sel_r;
        snap_s     = snap_r;
        if (!active_r) begin
            if (tx_en && !empty_s) begin
                pop_s      = 1'b1;
                start_s    = 1'b1;
                byte_s     = note_hdr_byte(head_s[8]);
                snap_s     = head_s[7:0];
                byte_sel_s = 1'b0;
                active_s   = 1'b1;
            end else begin
                active_s = 1'b0;
            end
        end else if (done_s) begin
            if (!byte_sel_r) begin
                // byte1 always follows, even after tx_en has dropped
                start_s    = 1'b1;
                byte_s     = snap_r;
                byte_sel_s = 1'b1;
            end else if (tx_en && !empty_s) begin
                pop_s      = 1'b1;
                start_s    = 1'b1;
                byte_s     = note_hdr_byte(head_s[8]);
                snap_s     = head_s[7:0];
                byte_sel_s = 1'b0;
            end else begin
                active_s   = 1'b0;
                byte_sel_s = 1'b0;
            end
        end else begin
            active_s = active_r;
        end
    end

    // Next FIFO pointers, sticky overflow and busy
    always_comb begin
        push_s = event_s & (~full_s | pop_s);
        drop_s = event_s & full_s & ~pop_s;
        if (tx_en) begin
            wr_ptr_s   = push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
            rd_ptr_s   = pop_s  ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
            overflow_s = overflow_r | drop_s;
        end else begin
            wr_ptr_s   = PTR_ZERO;
            rd_ptr_s   = PTR_ZERO;
            overflow_s = 1'b0;
        end
        busy_s = active_s | (wr_ptr_s != rd_ptr_s);
    end

    // Control and FIFO storage registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_r     <= 9'h000;
            en_q_r     <= 1'b0;
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            active_r   <= 1'b0;
            byte_sel_r <= 1'b0;
            snap_r     <= 8'h00;
            busy_r     <= 1'b0;
            overflow_r <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_r[i] <= 9'h000;
            end
        end else begin
            prev_r     <= Pin_Note;
            en_q_r     <= tx_en;
            wr_ptr_r   <= wr_ptr_s;
            rd_ptr_r   <= rd_ptr_s;
            active_r   <= active_s;
            byte_sel_r <= byte_sel_s;
            snap_r     <= snap_s;
            busy_r     <= busy_s;
            overflow_r <= overflow_s;
            if (push_s) begin
                fifo_r[wr_ptr_r[AW-1:0]] <= Pin_Note;
            end
        end
    end

    uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_tx (
        .clk    (clk),
        .rst    (rst),
        .start  (start_s),
        .data   (byte_s),
        .done   (done_s),
        .uart_tx(uart_tx)
    );

    assign busy     = busy_r;
    assign overflow = overflow_r;

endmodule

// File: doc/note_uart_tx.md
# note_uart_tx

Note-event UART transmitter: watches the 9-bit piano key vector and reports every change of key state to the PC as a 2-byte serial frame. It is the outbound counterpart of the UART receive path in the virtual machine. It is instantiated beside `uart_loop` and gated by the VM's UART enable (`current_ENABLE[2]`). A 4-entry snapshot FIFO absorbs bursts of key activity while bytes are shifting out.

## Interface
Parameters:
- `CLK_FREQ`, 100_000_000 — clock frequency in Hz.
- `BAUD`, 9600 — line rate. `CLKS_PER_BIT = CLK_FREQ/BAUD` (integer division, must be ≥ 2).
- `FIFO_DEPTH`, 4 — number of snapshot entries; must be a power of two.

Ports:
- `clk` — input, 1 — system clock.
- `rst` — input, 1 — reset, asynchronous, active-low.
- `tx_en` — input, 1 — UART enable from the VM decode stage.
- `Pin_Note` — input, 9 — key vector; bit 0 is the LSB. It is synchronous to `clk` and already debounced upstream.
- `uart_tx` — output, 1 — serial line; idle high.
- `busy` — output, 1 — high while a frame is shifting or the FIFO is non-empty.
- `overflow` — output, 1 — sticky; set when a snapshot is dropped because the FIFO is full.

## Operation
- `prev` register (9 bits) loads `Pin_Note` every cycle regardless of `tx_en`. It resets to 0.
- `en_q` register delays `tx_en` by one cycle. `en_rise = tx_en & ~en_q`.
- Event condition: `tx_en & ((Pin_Note != prev) | en_rise)`. On an event, the current `Pin_Note` snapshot is written to the FIFO.
  - `en_rise` sends the initial key state.
  - Multiple changed bits in one cycle produce one snapshot.
- FIFO full:
  - With no pop in the same cycle, the snapshot is dropped and `overflow` is set.
  - Write and pop in the same cycle while full are both accepted.
- Frame per snapshot `n`:
  - byte0 = `{4'hA, 3'b000, n[8]}`.
  - byte1 = `n[7:0]`.
  - Each byte is sent as 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1).
- TX FSM states:
  - IDLE: `uart_tx` = 1. If FIFO is non-empty, pop, latch the snapshot, set `byte_sel` = 0, go to START.
  - START: `uart_tx` = 0 for `CLKS_PER_BIT` cycles, then go to DATA with `bit_idx` = 0.
  - DATA: `uart_tx` = the current byte's `[bit_idx]`. Each bit lasts `CLKS_PER_BIT` cycles. After bit 7, go to STOP.
  - STOP: `uart_tx` = 1 for `CLKS_PER_BIT` cycles, then:
    - if `byte_sel` = 0: set `byte_sel` = 1, go to START;
    - else if FIFO is non-empty and `tx_en` is high: pop and go to START with `byte_sel` = 0;
    - else go to IDLE.
- `tx_en` falling:
  - FIFO is flushed on the next edge.
  - A frame in progress completes both bytes; no further pops.
  - `overflow` clears while `tx_en` is low.
- Baud counter wraps to 0 on reaching `CLKS_PER_BIT-1`; bit/state advance happens on that wrap.

## Timing
- Reset values:
  - `uart_tx` = 1, `busy` = 0, `overflow` = 0.
  - FSM = IDLE, FIFO empty.
  - `prev` = 0, `en_q` = 0, all counters 0.
- Latency with the FIFO empty and the FSM in IDLE:
  - `Pin_Note` change is visible in cycle N.
  - FIFO write occurs at the end of N.
  - Pop and START occur at the end of N+1.
  - `uart_tx` falls at the edge ending N+1, i.e. 2 cycles after the change.
- Frame length: `20*CLKS_PER_BIT` cycles. There is no idle gap between byte0 and byte1, nor between back-to-back frames.
- `busy` is registered. It rises with the FIFO write and falls at the edge where the FSM enters IDLE with the FIFO empty.
- Reset asserted mid-frame: all state returns to reset values immediately; `uart_tx` goes high asynchronously.

## Structure
- `para.v` additions:
  - `` `TX_IDLE ``, `` `TX_START ``, `` `TX_DATA ``, `` `TX_STOP `` (2-bit state encodings).
  - `` `NOTE_FRAME_HDR `` (4'hA).
  - `` `UART_LINE_IDLE `` (1'b1).
- Sub-module `uart_byte_tx`: takes a byte plus a start strobe and returns a done pulse. It contains the START/DATA/STOP shifter and the baud counter.
- The top level holds the change detector, the FIFO (pointers with an extra wrap bit), the `byte_sel` sequencing and the `overflow` flag.

## Test plan
Bench parameters: `CLK_FREQ`=1000, `BAUD`=100 (10 clocks per bit).
- Reset, `tx_en`=1, `Pin_Note`=0 → `en_rise` sends frame 0xA0, 0x00. Line stays high ≥200 cycles afterward.
- `Pin_Note` 0 → 9'h105 → after 2 cycles start bit; bytes 0xA1, 0x05 decoded LSB-first; 200-cycle frame; `busy` falls after the stop bit.
- Six changes 1 cycle apart while idle → first popped; 4 queued; 6th dropped, `overflow`=1. Exactly 5 frames emitted, in order.
- `tx_en` dropped mid-byte0 with 2 entries queued → current frame's both bytes finish; remaining entries discarded; `overflow` cleared; line idle.
- `rst` low during DATA bit 3 → `uart_tx`=1, `busy`=0 immediately. After release with `tx_en`=1, only the `en_rise` snapshot is sent.
- Change while `tx_en`=0 → no frame. Raising `tx_en` sends exactly one frame carrying the current `Pin_Note`.
